maxpool_2x2_stage: RTL and testbench

- Downstream consumer of the ping-pong IFM memory array: reads one full IFM plane through the dual "next" read ports (A = even row, B = odd row).
- Computes a 2x2 stride-2 max-pool and writes each pooled word into the next stage's memory, one write per output.
- Runs one plane per start pulse; top-level control flips the bank select after done.

---
 rtl/lenet_pkg.sv | 22 ++
 rtl/maxpool_2x2_stage_if.sv | 41 ++++
 rtl/max_2_signed.sv | 14 +
 rtl/maxpool_2x2_stage.sv | 132 +++++++++++++
 tb/tb_maxpool_2x2_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the pooling stage: controller states, default
// datapath geometry and the OFM address-width helper.
package lenet_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_IFM_SIZE   = 14;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_L = 3'd1,
        RD_R = 3'd2,
        CMP  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } pool_state_t;

    // Address width needed for a (ifm_size/2)^2 output plane.
    function automatic int ofm_addr_width(input int ifm_size);
        return $clog2((ifm_size / 2) * (ifm_size / 2));
    endfunction

endpackage

// File: rtl/maxpool_2x2_stage_if.sv
// Bus between the pooling stage and its memories: control handshake, the
// dual IFM "next" read ports and the OFM write port.
// master = pooling stage, slave = memories / top-level control.
interface maxpool_2x2_stage_if
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_SIZE_IFM = $clog2(DEFAULT_IFM_SIZE * DEFAULT_IFM_SIZE),
    parameter int ADDRESS_SIZE_OFM = ofm_addr_width(DEFAULT_IFM_SIZE)
);

    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        ifm_enable_read_A_next;
    logic                        ifm_enable_read_B_next;
    logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next;
    logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next;
    logic [DATA_WIDTH-1:0]       data_in_A;
    logic [DATA_WIDTH-1:0]       data_in_B;
    logic                        ofm_enable_write;
    logic [ADDRESS_SIZE_OFM-1:0] ofm_address_write;
    logic [DATA_WIDTH-1:0]       ofm_data_out;

    modport master (
        input  start, data_in_A, data_in_B,
        output busy, done,
               ifm_enable_read_A_next, ifm_enable_read_B_next,
               ifm_address_read_A_next, ifm_address_read_B_next,
               ofm_enable_write, ofm_address_write, ofm_data_out
    );

    modport slave (
        output start, data_in_A, data_in_B,
        input  busy, done,
               ifm_enable_read_A_next, ifm_enable_read_B_next,
               ifm_address_read_A_next, ifm_address_read_B_next,
               ofm_enable_write, ofm_address_write, ofm_data_out
    );

endinterface

// File: rtl/max_2_signed.sv
// Combinational signed maximum of two words; a tie returns operand a.
module max_2_signed
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = ($signed(b) > $signed(a)) ? b : a;

endmodule

// File: rtl/maxpool_2x2_stage.sv
// 2x2 stride-2 max-pool over one IFM plane per start pulse.
// Row pair (2r, 2r+1) is read through ports A/B; left column then right
// column, then the pooled word is written to OFM address r*OFM_SIZE+c.
// Optional build macro MAXPOOL_RELU_EN: negative pooled words are written as 0.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start
//   RD_L  | read left column of the 2x2 window (A even row, B odd row)
//   RD_R  | read right column; capture max of the left column
//   CMP   | combine left/right maxima into the output register
//   WR    | write strobe for one pooled word; advance r/c
//   DONE  | one-cycle done pulse
module maxpool_2x2_stage
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int IFM_SIZE         = DEFAULT_IFM_SIZE,
    parameter int OFM_SIZE         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_OFM = ofm_addr_width(IFM_SIZE)
) (
    input logic                 clk,
    input logic                 reset,
    maxpool_2x2_stage_if.master bus
);

    localparam int RC_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

    pool_state_t           state, state_nxt;
    logic [RC_W-1:0]       r, c;
    logic [DATA_WIDTH-1:0] max_l;
    logic [DATA_WIDTH-1:0] left_max, right_max, final_max, pooled;
    logic [DATA_WIDTH-1:0] ofm_data_q;
    logic [ADDRESS_SIZE_OFM-1:0] ofm_addr_q;
    logic [ADDRESS_SIZE_IFM-1:0] addr_base;
    logic                  rd_phase;
    logic                  last_out;

    max_2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_left (
        .a(bus.data_in_A), .b(bus.data_in_B), .y(left_max)
    );

    max_2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_right (
        .a(bus.data_in_A), .b(bus.data_in_B), .y(right_max)
    );

    max_2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_final (
        .a(max_l), .b(right_max), .y(final_max)
    );

`ifdef MAXPOOL_RELU_EN
    assign pooled = final_max[DATA_WIDTH-1] ? '0 : final_max;
`else
    assign pooled = final_max;
`endif

    assign last_out  = (r == RC_W'(OFM_SIZE - 1)) && (c == RC_W'(OFM_SIZE - 1));
    assign rd_phase  = (state == RD_L) || (state == RD_R);
    assign addr_base = ADDRESS_SIZE_IFM'(2 * 32'(r) * IFM_SIZE + 2 * 32'(c));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RD_L;
            RD_L:    state_nxt = RD_R;
            RD_R:    state_nxt = CMP;
            CMP:     state_nxt = WR;
            WR:      state_nxt = last_out ? DONE : RD_L;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window position, left-column max and the registered output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r          <= '0;
            c          <= '0;
            max_l      <= '0;
            ofm_data_q <= '0;
            ofm_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r <= '0;
                        c <= '0;
                    end
                end
                RD_R: max_l <= left_max;
                CMP: begin
                    ofm_data_q <= pooled;
                    ofm_addr_q <= ADDRESS_SIZE_OFM'(32'(r) * OFM_SIZE + 32'(c));
                end
                WR: begin
                    // Wrap r as well on the final output so r/c never leave range.
                    if (last_out) begin
                        r <= '0;
                        c <= '0;
                    end else if (c == RC_W'(OFM_SIZE - 1)) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy                    = (state != IDLE);
    assign bus.done                    = (state == DONE);
    assign bus.ifm_enable_read_A_next  = rd_phase;
    assign bus.ifm_enable_read_B_next  = rd_phase;
    assign bus.ifm_address_read_A_next = rd_phase
        ? addr_base + ADDRESS_SIZE_IFM'(state == RD_R) : '0;
    assign bus.ifm_address_read_B_next = rd_phase
        ? addr_base + ADDRESS_SIZE_IFM'(state == RD_R) + ADDRESS_SIZE_IFM'(IFM_SIZE) : '0;
    assign bus.ofm_enable_write        = (state == WR);
    assign bus.ofm_address_write       = ofm_addr_q;
    assign bus.ofm_data_out            = ofm_data_q;

endmodule

// File: tb/tb_maxpool_2x2_stage.sv
// Directed bench for maxpool_2x2_stage (default 14x14 plane, 32-bit words).
module tb_maxpool_2x2_stage;

    localparam int IFM  = 14;
    localparam int OFM  = 7;
    localparam int NPIX = IFM * IFM;
    localparam int NOUT = OFM * OFM;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    maxpool_2x2_stage_if #(.DATA_WIDTH(32), .ADDRESS_SIZE_IFM(8), .ADDRESS_SIZE_OFM(6)) bus ();

    maxpool_2x2_stage #(.DATA_WIDTH(32), .IFM_SIZE(IFM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic signed [31:0] mem     [0:NPIX-1];
    logic signed [31:0] wr_data [0:NOUT-1];

    int cyc = 0, t0 = 0;
    int wr_total = 0, wr_base = 0, done_total = 0, done_base = 0, done_cyc = 0;
    int last_wr_cyc = 0, en_total = 0, en_base = 0;
    int en_mis = 0, diff_err = 0, range_err = 0, order_err = 0;
    int wr_at_rst = 0;
    int checks = 0, passed = 0, fails = 0;
    logic b1, b196, b198;
    logic p_busy, p_en_a, p_en_b, p_wen, p_done;
    logic [31:0] p_data;
    logic [5:0]  p_waddr;
    logic [7:0]  p_aaddr;

`ifdef MAXPOOL_RELU_EN
    localparam logic signed [31:0] EXP_NEG5 = 0;
    localparam logic signed [31:0] EXP_NEG1 = 0;
`else
    localparam logic signed [31:0] EXP_NEG5 = -5;
    localparam logic signed [31:0] EXP_NEG1 = -1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // IFM memory model: registered read, data valid one cycle after enable.
    always @(posedge clk) begin
        if (reset) begin
            bus.data_in_A <= '0;
            bus.data_in_B <= '0;
        end else begin
            if (bus.ifm_enable_read_A_next) bus.data_in_A <= mem[bus.ifm_address_read_A_next];
            if (bus.ifm_enable_read_B_next) bus.data_in_B <= mem[bus.ifm_address_read_B_next];
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.ofm_enable_write) begin
            if (int'(bus.ofm_address_write) != (wr_total - wr_base)) order_err <= order_err + 1;
            if (int'(bus.ofm_address_write) < NOUT) wr_data[bus.ofm_address_write] <= bus.ofm_data_out;
            wr_total    <= wr_total + 1;
            last_wr_cyc <= cyc - t0;
        end
        if (bus.done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc - t0;
        end
        if (bus.ifm_enable_read_A_next) en_total <= en_total + 1;
        if (bus.ifm_enable_read_A_next !== bus.ifm_enable_read_B_next) en_mis <= en_mis + 1;
        if (bus.ifm_enable_read_A_next &&
            (int'(bus.ifm_address_read_B_next) != int'(bus.ifm_address_read_A_next) + IFM))
            diff_err <= diff_err + 1;
        if (bus.ifm_enable_read_B_next && int'(bus.ifm_address_read_B_next) > NPIX - 1)
            range_err <= range_err + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_addr();
        for (int i = 0; i < NPIX; i++) mem[i] = i;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NPIX; i++) mem[i] = v;
    endtask

    // Pulse start (cycle 0), then run a fixed number of cycles with optional
    // extra start pulses and an optional one-cycle reset.
    task automatic run_plane(input int re1, input int re2, input int rst_at, input int bound);
        @(negedge clk);
        wr_base   = wr_total;
        done_base = done_total;
        en_base   = en_total;
        t0        = cyc;
        bus.start = 1'b1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            bus.start = (k == re1) || (k == re2);
            reset     = (k == rst_at);
            if (k == 1)   b1   = bus.busy;
            if (k == 196) b196 = bus.busy;
            if (k == 198) b198 = bus.busy;
            if (rst_at > 0 && k == rst_at) wr_at_rst = wr_total - wr_base;
            if (rst_at > 0 && k == rst_at + 1) begin
                p_busy  = bus.busy;
                p_en_a  = bus.ifm_enable_read_A_next;
                p_en_b  = bus.ifm_enable_read_B_next;
                p_wen   = bus.ofm_enable_write;
                p_done  = bus.done;
                p_data  = bus.ofm_data_out;
                p_waddr = bus.ofm_address_write;
                p_aaddr = bus.ifm_address_read_A_next;
            end
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        int bad;
        bus.start = 1'b0;
        reset     = 1'b1;
        fill_const(0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_en_a",  bus.ifm_enable_read_A_next, 0);
        check("rst_en_b",  bus.ifm_enable_read_B_next, 0);
        check("rst_wen",   bus.ofm_enable_write, 0);
        check("rst_waddr", bus.ofm_address_write, 0);
        check("rst_data",  bus.ofm_data_out, 0);
        check("rst_aaddr", bus.ifm_address_read_A_next, 0);

        // Plane value = address.
        fill_addr();
        run_plane(-1, -1, -1, 205);
        check("ramp_writes",   wr_total - wr_base, 49);
        check("ramp_addr0",    wr_data[0], 15);
        check("ramp_addr6",    wr_data[6], 27);
        check("ramp_addr48",   wr_data[48], 195);
        bad = 0;
        for (int r = 0; r < OFM; r++)
            for (int c = 0; c < OFM; c++)
                if (wr_data[r*OFM+c] !== 32'((2*r+1)*IFM + 2*c + 1)) bad++;
        check("ramp_all_bad",  bad, 0);
        check("ramp_done_cyc", done_cyc, 197);
        check("ramp_last_wr",  last_wr_cyc, 196);
        check("ramp_done_cnt", done_total - done_base, 1);
        check("busy_cyc1",     b1, 1);
        check("busy_cyc196",   b196, 1);
        check("busy_cyc198",   b198, 0);
        check("rd_en_cycles",  en_total - en_base, 98);
        check("rd_en_ab_mis",  en_mis, 0);
        check("rd_addr_diff",  diff_err, 0);
        check("rd_addr_range", range_err, 0);
        check("wr_order",      order_err, 0);

        // All -5.
        fill_const(-5);
        run_plane(-1, -1, -1, 205);
        check("neg5_writes", wr_total - wr_base, 49);
        check("neg5_addr10", wr_data[10], EXP_NEG5);
        bad = 0;
        for (int i = 0; i < NOUT; i++) if (wr_data[i] !== EXP_NEG5) bad++;
        check("neg5_all_bad", bad, 0);

        // Isolated windows on a zero plane.
        fill_const(0);
        mem[62]  = 3;  mem[63]  = -7; mem[76]  = 3;  mem[77]  = 2;
        mem[114] = -1; mem[115] = -2; mem[128] = -3; mem[129] = -4;
        mem[0]   = 1;  mem[1]   = 2;  mem[14]  = 3;  mem[15]  = 9;
        run_plane(-1, -1, -1, 205);
        check("win_3_mixed", wr_data[17], 3);
        check("win_all_neg", wr_data[29], EXP_NEG1);
        check("win_br_max",  wr_data[0], 9);
        bad = 0;
        for (int i = 0; i < NOUT; i++)
            if (i != 0 && i != 17 && i != 29 && wr_data[i] !== 32'sd0) bad++;
        check("win_rest_bad", bad, 0);

        // Start re-pulsed mid-plane.
        fill_addr();
        run_plane(10, 100, -1, 205);
        check("repulse_writes",   wr_total - wr_base, 49);
        check("repulse_done_cnt", done_total - done_base, 1);
        check("repulse_done_cyc", done_cyc, 197);
        check("repulse_addr48",   wr_data[48], 195);

        // Reset at cycle 50, then a clean restart.
        run_plane(-1, -1, 50, 250);
        check("mid_rst_busy",   p_busy, 0);
        check("mid_rst_en_a",   p_en_a, 0);
        check("mid_rst_en_b",   p_en_b, 0);
        check("mid_rst_wen",    p_wen, 0);
        check("mid_rst_done",   p_done, 0);
        check("mid_rst_data",   p_data, 0);
        check("mid_rst_waddr",  p_waddr, 0);
        check("mid_rst_aaddr",  p_aaddr, 0);
        check("mid_rst_pre_wr", wr_at_rst, 12);
        check("mid_rst_no_wr",  wr_total - wr_base, 12);
        check("mid_rst_nodone", done_total - done_base, 0);
        run_plane(-1, -1, -1, 205);
        check("restart_writes", wr_total - wr_base, 49);
        check("restart_addr0",  wr_data[0], 15);
        check("restart_done",   done_total - done_base, 1);
        check("restart_order",  order_err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
